// File: rtl/lcd_timing_pkg.sv
// Shared constants for the LCD scanout block: RGB565 field layout,
// default 480x272 panel timing and the background mode encoding.
package lcd_timing_pkg;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int RGB_W = R_W + G_W + B_W;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 4;
    localparam int DEF_H_BP     = 39;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 8;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 8;

    typedef enum logic {
        BG_SOLID    = 1'b0,
        BG_GRADIENT = 1'b1
    } bg_mode_t;

    typedef logic [RGB_W-1:0] rgb565_t;

endpackage

// File: rtl/lcd_window_scanout_if.sv
// Framebuffer read port plus panel-side outputs of the scanout block.
// master = scanout engine, slave = framebuffer RAM / panel side.
interface lcd_window_scanout_if
    import lcd_timing_pkg::*;
#(
    parameter int AW = 12
);
    logic [AW-1:0]    ram_addr;
    logic [RGB_W-1:0] ram_data;
    logic             lcd_hsync;
    logic             lcd_vsync;
    logic             lcd_den;
    logic [R_W-1:0]   lcd_r;
    logic [G_W-1:0]   lcd_g;
    logic [B_W-1:0]   lcd_b;
    logic             frame_start;
    logic             line_start;

    modport master (
        output ram_addr, lcd_hsync, lcd_vsync, lcd_den,
        output lcd_r, lcd_g, lcd_b, frame_start, line_start,
        input  ram_data
    );

    modport slave (
        input  ram_addr, lcd_hsync, lcd_vsync, lcd_den,
        input  lcd_r, lcd_g, lcd_b, frame_start, line_start,
        output ram_data
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Horizontal/vertical raster counters and the undelayed timing decode
// (sync, active region, first-pixel-of-line/frame) derived from them.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 39,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 8,
    parameter int HW       = 10,
    parameter int VW       = 9
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          h_act,
    output logic          v_act,
    output logic          frame_first,
    output logic          line_first
);
    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;

    // Raster position: h wraps every line, v advances on the h wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == HW'(H_TOTAL - 1)) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == VW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    // Phase order within a line/frame is sync, back porch, active, front porch.
    always_comb begin
        h_cnt       = h_cnt_reg;
        v_cnt       = v_cnt_reg;
        hsync_act   = (h_cnt_reg < HW'(H_SYNC));
        vsync_act   = (v_cnt_reg < VW'(V_SYNC));
        h_act       = (h_cnt_reg >= HW'(H_ACT_START)) && (h_cnt_reg < HW'(H_ACT_END));
        v_act       = (v_cnt_reg >= VW'(V_ACT_START)) && (v_cnt_reg < VW'(V_ACT_END));
        line_first  = (h_cnt_reg == '0);
        frame_first = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end
endmodule

// File: rtl/lcd_window_scanout.sv
// Scans out a scaled framebuffer window over a solid or gradient background.
// Stage 0 decodes the raster position and drives the RAM address directly,
// stage 1 sees the RAM word, stage 2 registers every panel output, so all
// panel signals lag the counters by exactly two clocks.
module lcd_window_scanout
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int WIN_X      = 160,
    parameter int WIN_Y      = 18,
    parameter int COL_LOG2   = 6,
    parameter int ROW_LOG2   = 6,
    parameter int SCALE_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bg_mode,
    input  logic [RGB_W-1:0]      bg_color,
    input  logic                  win_en,
    lcd_window_scanout_if.master  bus
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = ROW_LOG2 + COL_LOG2;
    localparam int WIN_W   = (1 << COL_LOG2) << SCALE_LOG2;
    localparam int WIN_H   = (1 << ROW_LOG2) << SCALE_LOG2;
    localparam int X_OFS   = H_SYNC + H_BP;
    localparam int Y_OFS   = V_SYNC + V_BP;

    // Reject nonsensical timing or a window origin outside the active area.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        COL_LOG2 < 1 || ROW_LOG2 < 1 || SCALE_LOG2 < 0 ||
        WIN_X < 0 || WIN_Y < 0 || WIN_X >= H_ACTIVE || WIN_Y >= V_ACTIVE) begin : g_param_check
        $error("lcd_window_scanout: illegal timing or window parameters");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hsync_act, vsync_act, h_act, v_act, frame_first, line_first;

    lcd_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .rst(rst),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync_act(hsync_act), .vsync_act(vsync_act),
        .h_act(h_act), .v_act(v_act),
        .frame_first(frame_first), .line_first(line_first)
    );

    bg_mode_t bg_mode_reg;
    rgb565_t  bg_color_reg;
    logic     win_en_reg;

    // Controls are latched on the first pixel of a frame so a frame never mixes modes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bg_mode_reg  <= BG_SOLID;
            bg_color_reg <= '0;
            win_en_reg   <= 1'b0;
        end else if (frame_first) begin
            bg_mode_reg  <= bg_mode_t'(bg_mode);
            bg_color_reg <= bg_color;
            win_en_reg   <= win_en;
        end
    end

    logic [31:0]         x_pos, y_pos;
    logic                in_win;
    logic [COL_LOG2-1:0] col;
    logic [ROW_LOG2-1:0] row;
    logic [AW-1:0]       ram_addr;
    logic [AW-1:0]       addr_last_reg;
    rgb565_t             bg_pix;

    // Stage 0: window hit test and RAM address; outside the window the address
    // is frozen so the RAM sees no reads it does not need. Requiring h_act/v_act
    // clips the window at the active edge instead of wrapping it.
    always_comb begin
        x_pos    = 32'(h_cnt) - 32'(X_OFS);
        y_pos    = 32'(v_cnt) - 32'(Y_OFS);
        in_win   = h_act && v_act &&
                   (x_pos >= 32'(WIN_X)) && (x_pos < 32'(WIN_X + WIN_W)) &&
                   (y_pos >= 32'(WIN_Y)) && (y_pos < 32'(WIN_Y + WIN_H));
        col      = COL_LOG2'((x_pos - 32'(WIN_X)) >> SCALE_LOG2);
        row      = ROW_LOG2'((y_pos - 32'(WIN_Y)) >> SCALE_LOG2);
        ram_addr = in_win ? {row, col} : addr_last_reg;
        bg_pix   = (bg_mode_reg == BG_GRADIENT) ? RGB_W'(32'(h_cnt) + 32'(v_cnt))
                                                : bg_color_reg;
    end

    assign bus.ram_addr = ram_addr;

    logic    s1_hs, s1_vs, s1_den, s1_win, s1_fs, s1_ls;
    rgb565_t s1_bg;

    // Stage 1: carry timing and background alongside the outstanding RAM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hs         <= 1'b0;
            s1_vs         <= 1'b0;
            s1_den        <= 1'b0;
            s1_win        <= 1'b0;
            s1_fs         <= 1'b0;
            s1_ls         <= 1'b0;
            s1_bg         <= '0;
            addr_last_reg <= '0;
        end else begin
            s1_hs         <= hsync_act;
            s1_vs         <= vsync_act;
            s1_den        <= h_act && v_act;
            s1_win        <= in_win && win_en_reg;
            s1_fs         <= frame_first;
            s1_ls         <= line_first;
            s1_bg         <= bg_pix;
            addr_last_reg <= ram_addr;
        end
    end

    rgb565_t pix_colour;

    // Colour select: blanked outside the active area, RAM word inside the window.
    always_comb begin
        pix_colour = '0;
        if (s1_den) begin
            pix_colour = s1_win ? bus.ram_data : s1_bg;
        end
    end

    logic    hsync_reg, vsync_reg, den_reg, fs_reg, ls_reg;
    rgb565_t colour_reg;

    // Stage 2: register every panel-facing output together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_reg  <= ~SYNC_POL;
            vsync_reg  <= ~SYNC_POL;
            den_reg    <= 1'b0;
            fs_reg     <= 1'b0;
            ls_reg     <= 1'b0;
            colour_reg <= '0;
        end else begin
            hsync_reg  <= s1_hs ? SYNC_POL : ~SYNC_POL;
            vsync_reg  <= s1_vs ? SYNC_POL : ~SYNC_POL;
            den_reg    <= s1_den;
            fs_reg     <= s1_fs;
            ls_reg     <= s1_ls;
            colour_reg <= pix_colour;
        end
    end

    assign bus.lcd_hsync   = hsync_reg;
    assign bus.lcd_vsync   = vsync_reg;
    assign bus.lcd_den     = den_reg;
    assign bus.frame_start = fs_reg;
    assign bus.line_start  = ls_reg;
    assign bus.lcd_r       = colour_reg[RGB_W-1 -: R_W];
    assign bus.lcd_g       = colour_reg[B_W +: G_W];
    assign bus.lcd_b       = colour_reg[B_W-1:0];
endmodule

// File: tb/tb_lcd_window_scanout.sv
// Directed bench: instance A uses default 480x272 timing with a 4x scaled
// window, instance B a tiny 8x4 raster (H 8/2/1/1, V 4/1/1/1) with 1:1
// scale, active-high syncs and a window clipped at the right edge.
// idx is the raster position whose pixel is on the outputs at each sample.
module tb_lcd_window_scanout;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bg_mode = 1'b0;
    logic [15:0] bg_color = 16'hF81F;
    logic        win_en = 1'b1;

    int n_vec = 0;
    int n_bad = 0;
    int idx = -2;
    int hs_a_cnt = 0, hs_b_cnt = 0, vs_b_cnt = 0, den_b_cnt = 0;

    lcd_window_scanout_if #(.AW(12)) a_if ();
    lcd_window_scanout_if #(.AW(3))  b_if ();

    lcd_window_scanout u_a (
        .clk(clk), .rst(rst), .bg_mode(bg_mode), .bg_color(bg_color),
        .win_en(win_en), .bus(a_if)
    );

    lcd_window_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .WIN_X(6), .WIN_Y(1),
        .COL_LOG2(2), .ROW_LOG2(1), .SCALE_LOG2(0)
    ) u_b (
        .clk(clk), .rst(rst), .bg_mode(bg_mode), .bg_color(bg_color),
        .win_en(win_en), .bus(b_if)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models: one clock of read latency, data derived from address.
    always_ff @(posedge clk) a_if.ram_data <= {4'b0, a_if.ram_addr};
    always_ff @(posedge clk) b_if.ram_data <= 16'h0100 | {13'b0, b_if.ram_addr};

    logic [15:0] col_a, col_b;
    assign col_a = {a_if.lcd_r, a_if.lcd_g, a_if.lcd_b};
    assign col_b = {b_if.lcd_r, b_if.lcd_g, b_if.lcd_b};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s idx=%0d got=%0h want=%0h", tag, idx, got, want);
        end else begin
            $display("  ok   %s idx=%0d value=%0h", tag, idx, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idx++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_hs_a",  32'(a_if.lcd_hsync), 1);
        check_val("rst_hs_b",  32'(b_if.lcd_hsync), 0);
        check_val("rst_vs_b",  32'(b_if.lcd_vsync), 0);
        check_val("rst_den_b", 32'(b_if.lcd_den), 0);
        check_val("rst_fs_a",  32'(a_if.frame_start), 0);
        check_val("rst_addr_a", 32'(a_if.ram_addr), 0);
        rst = 1'b1;
        idx = -2;

        while (idx < 20920) begin
            step();
            if (idx >= 0 && idx < 84) begin
                if (a_if.lcd_hsync == 1'b0) hs_a_cnt++;
                if (b_if.lcd_hsync == 1'b1) hs_b_cnt++;
                if (b_if.lcd_vsync == 1'b1) vs_b_cnt++;
                if (b_if.lcd_den   == 1'b1) den_b_cnt++;
            end
            case (idx)
                0: begin
                    check_val("fs_b0", 32'(b_if.frame_start), 1);
                    check_val("ls_b0", 32'(b_if.line_start), 1);
                    check_val("hs_b0", 32'(b_if.lcd_hsync), 1);
                    check_val("vs_b0", 32'(b_if.lcd_vsync), 1);
                    check_val("fs_a0", 32'(a_if.frame_start), 1);
                    check_val("hs_a0", 32'(a_if.lcd_hsync), 0);
                    check_val("vs_a0", 32'(a_if.lcd_vsync), 0);
                end
                1: begin
                    check_val("fs_b1", 32'(b_if.frame_start), 0);
                    check_val("hs_b1", 32'(b_if.lcd_hsync), 0);
                    check_val("vs_b1", 32'(b_if.lcd_vsync), 1);
                end
                12: begin
                    check_val("ls_b12", 32'(b_if.line_start), 1);
                    check_val("vs_b12", 32'(b_if.lcd_vsync), 0);
                end
                13: check_val("ls_b13", 32'(b_if.line_start), 0);
                26: begin
                    check_val("den_b26", 32'(b_if.lcd_den), 1);
                    check_val("col_b26", 32'(col_b), 32'hF81F);
                end
                43: check_val("col_b43", 32'(col_b), 32'hF81F);
                44: begin
                    check_val("den_b44", 32'(b_if.lcd_den), 1);
                    check_val("col_b44", 32'(col_b), 32'h0100);
                end
                45: check_val("col_b45", 32'(col_b), 32'h0101);
                46: begin
                    check_val("den_b46", 32'(b_if.lcd_den), 0);
                    check_val("col_b46", 32'(col_b), 0);
                    check_val("addr_hold_b46", 32'(b_if.ram_addr), 1);
                end
                54: check_val("addr_b54", 32'(b_if.ram_addr), 4);
                56: check_val("col_b56", 32'(col_b), 32'h0104);
                57: check_val("col_b57", 32'(col_b), 32'h0105);
                58: check_val("addr_hold_b58", 32'(b_if.ram_addr), 5);
                84: begin
                    check_val("hs_a_width", 32'(hs_a_cnt), 4);
                    check_val("hs_b_pulses", 32'(hs_b_cnt), 7);
                    check_val("vs_b_width", 32'(vs_b_cnt), 12);
                    check_val("den_b_count", 32'(den_b_cnt), 32);
                    check_val("fs_b84", 32'(b_if.frame_start), 1);
                end
                90: begin
                    bg_mode = 1'b1;
                    win_en  = 1'b0;
                end
                127: check_val("held_bg_b127", 32'(col_b), 32'hF81F);
                128: check_val("held_win_b128", 32'(col_b), 32'h0100);
                167: check_val("fs_b167", 32'(b_if.frame_start), 0);
                168: check_val("fs_b168", 32'(b_if.frame_start), 1);
                211: check_val("grad_b211", 32'(col_b), 32'h000A);
                212: check_val("grad_b212", 32'(col_b), 32'h000B);
                19855: check_val("col_a_r1c1", 32'(col_a), 32'h0041);
                20911: check_val("col_a_bg", 32'(col_a), 32'hF81F);
                20915: check_val("col_a_r2c0", 32'(col_a), 32'h0080);
                20916: check_val("col_a_r2c1a", 32'(col_a), 32'h0081);
                20917: begin
                    check_val("col_a_r2c1b", 32'(col_a), 32'h0081);
                    check_val("den_a", 32'(a_if.lcd_den), 1);
                    check_val("addr_a", 32'(a_if.ram_addr), 32'h081);
                end
                20920: begin
                    check_val("col_a_r2c2", 32'(col_a), 32'h0082);
                    check_val("addr_a2", 32'(a_if.ram_addr), 32'h082);
                end
                default: ;
            endcase
        end

        // Reset in the middle of an active line of instance B.
        while (idx % 84 != 44) step();
        check_val("den_b_pre_rst", 32'(b_if.lcd_den), 1);
        rst = 1'b0;
        #1;
        check_val("mid_rst_den_b", 32'(b_if.lcd_den), 0);
        check_val("mid_rst_den_a", 32'(a_if.lcd_den), 0);
        check_val("mid_rst_hs_b",  32'(b_if.lcd_hsync), 0);
        check_val("mid_rst_vs_b",  32'(b_if.lcd_vsync), 0);
        check_val("mid_rst_hs_a",  32'(a_if.lcd_hsync), 1);
        check_val("mid_rst_vs_a",  32'(a_if.lcd_vsync), 1);
        check_val("mid_rst_col_b", 32'(col_b), 0);
        check_val("mid_rst_addr_b", 32'(b_if.ram_addr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idx = -2;
        step();
        check_val("restart_fs_a_early", 32'(a_if.frame_start), 0);
        check_val("restart_fs_b_early", 32'(b_if.frame_start), 0);
        step();
        check_val("restart_fs_a", 32'(a_if.frame_start), 1);
        check_val("restart_fs_b", 32'(b_if.frame_start), 1);
        check_val("restart_hs_b", 32'(b_if.lcd_hsync), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_window_scanout.md
LCD_WINDOW_SCANOUT -- requirements
Module: lcd_window_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 8/4/39, horizontal front porch, sync and back porch in pixel clocks.
REQ-003 Parameter V_ACTIVE, default 272, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 8/4/8, vertical porches and sync in lines.
REQ-005 Parameter SYNC_POL, default 0, active level of lcd_hsync and lcd_vsync.
REQ-006 Parameters WIN_X/WIN_Y, defaults 160/18, window origin in active coordinates.
REQ-007 Parameters COL_LOG2/ROW_LOG2, defaults 6/6, framebuffer columns and rows as log2.
REQ-008 Parameter SCALE_LOG2, default 2, pixel replication factor as log2 (0 = 1:1).
REQ-009 clk  in  1  pixel clock.
REQ-010 rst  in  1  asynchronous active-low reset.
REQ-011 bg_mode  in  1  0 = solid bg_color, 1 = gradient.
REQ-012 bg_color  in  16  RGB565 background.
REQ-013 win_en  in  1  1 = show framebuffer window.
REQ-014 ram_addr  out  ROW_LOG2+COL_LOG2  framebuffer read address {row, col}.
REQ-015 ram_data  in  16  RGB565 read data, valid exactly one clk after ram_addr.
REQ-016 lcd_hsync, lcd_vsync, lcd_den  out  1 each  panel timing.
REQ-017 lcd_r/lcd_g/lcd_b  out  5/6/5  pixel colour.
REQ-018 frame_start, line_start  out  1 each  one-clk strobes.

Function
REQ-019 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP), wrap to 0, and advance v_cnt on wrap; v_cnt SHALL wrap at V_TOTAL.
REQ-020 Line phase order SHALL be sync, back porch, active, front porch; active x = h_cnt-(H_SYNC+H_BP), likewise y.
REQ-021 Stage 0 SHALL compute coordinates and ram_addr = {(y-WIN_Y)>>SCALE_LOG2, (x-WIN_X)>>SCALE_LOG2}; stage 1 receives ram_data; stage 2 registers all lcd_* outputs.
REQ-022 hsync, vsync, den, colour and strobes SHALL be delayed identically by two clk, so pixel (x,y) and its den appear on the same cycle.
REQ-023 Window SHALL be WIN_X <= x < WIN_X+(2^COL_LOG2<<SCALE_LOG2), same for y; inside window and win_en=1 colour = ram_data.
REQ-024 Outside window, or win_en=0, colour SHALL be bg_color (bg_mode=0) or (h_cnt+v_cnt) mod 2^16 (bg_mode=1).
REQ-025 When den=0, lcd_r/g/b SHALL be 0.
REQ-026 ram_addr outside the window SHALL hold its last value (no spurious reads).
REQ-027 bg_mode, bg_color and win_en SHALL be sampled once at h_cnt=0,v_cnt=0 and held for the frame.
REQ-028 frame_start SHALL pulse with the output of h_cnt=0,v_cnt=0; line_start with each h_cnt=0.
REQ-029 Window clipped by active area SHALL be truncated, not wrapped.
REQ-030 Parameter sanity (all timing >= 1, window origin < active size) SHALL be checked at elaboration.

Reset
REQ-031 On rst low: counters 0, pipeline cleared, lcd_den 0, colour 0, strobes 0, syncs at inactive level (~SYNC_POL), ram_addr 0.
REQ-032 Reset mid-frame SHALL abort immediately; first frame_start follows two clk after rst release.

Structure
REQ-033 Package lcd_timing_pkg SHALL hold RGB565 field widths, default 480x272 timing constants and the bg_mode encoding.
REQ-034 One sub-module lcd_timing_gen (counters, sync/den, strobes) is natural; windowing and pipeline stay in the top.

Verification
REQ-035 Small timing (H 8/1/1/2, V 4/1/1/1): hsync period 12 clk, 1 clk wide; vsync 7 lines, den 8 of 12 per active line.
REQ-036 Default timing, win_en=1, RAM model returning addr as data: pixel at x=WIN_X+5, y=WIN_Y+9 shows addr {2,1}.
REQ-037 SCALE_LOG2=0 vs 2: each RAM word repeated 1 vs 4 horizontally and vertically.
REQ-038 bg_mode toggled mid-frame: output unchanged until next frame_start.
REQ-039 rst asserted mid-line: den 0, syncs inactive same cycle; restart frame_start at two clk after release.
REQ-040 SYNC_POL=1: sync pulses high, inactive low, including during reset.
